// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state
//   encoding, default memory depth and word-address width.
package imem_loader_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int ADDR_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream input and instruction-memory write port of the loader.
//   rx_data/rx_valid/rx_ready : incoming program bytes (valid/ready)
//   we/waddr/wdata            : instruction-memory write strobe, word
//                               address and 32-bit word
//   master modport = loader side, slave modport = byte source / memory.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, we, waddr, wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
//   Collects four bytes little-endian into a 32-bit word (first byte ends
//   up in bits [7:0]).
//   clk, reset(async low), clr : clock, reset, restart packing
//   i_vld, i_byte              : byte accepted this cycle
//   o_full                     : this accepted byte is the 4th of a word
//   o_word                     : complete word including the current byte
//                                (meaningful when o_full=1)
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    output logic        o_full,
    output logic [31:0] o_word
);
    logic [1:0]  r_cnt;
    logic [31:0] r_shift;

    // Shifting in from the top makes the first byte land in [7:0] after 4.
    assign o_word = {i_byte, r_shift[31:8]};
    assign o_full = i_vld && (r_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_vld) begin
            r_cnt   <= r_cnt + 2'd1;   // wraps to 0 after the 4th byte
            r_shift <= o_word;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program over a byte stream and writes it into instruction
//   memory while holding the CPU in reset.
//   Stream format: N low byte, N high byte, N words of 4 bytes each
//   (little-endian), then optionally one XOR checksum byte.
//   Ports:
//     clk, reset      : clock, async active-low reset
//     start           : one-cycle load request (honoured in IDLE/DONE/ERR)
//     bus (master)    : rx byte stream in, memory write port out
//     cpu_hold        : keep CPU in reset (all states except IDLE/DONE)
//     busy/done/err   : load in progress / last load ok / last load aborted
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
//   checksum byte equal to the XOR of all payload bytes.
module imem_loader #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_loader_if.master        bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    import imem_loader_pkg::*;

    localparam int unsigned MAX_N = 1 << ADDR_W;

    state_t            r_state, w_next;
    logic [15:0]       r_n;
    logic [ADDR_W:0]   r_idx;        // one extra bit so N=2**ADDR_W never wraps
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic              w_rx_ready, w_we;
    logic              w_acc, w_start, w_n_bad, w_last, w_full;
    logic [15:0]       w_n_full;
    logic [ADDR_W:0]   w_idx_nxt;
    logic [31:0]       w_word;

    assign w_acc     = bus.rx_valid && w_rx_ready;
    assign w_start   = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_n_full  = {bus.rx_data, r_n[7:0]};
    assign w_n_bad   = (w_n_full == 16'd0) || ({16'd0, w_n_full} > MAX_N);
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (r_n == 16'(w_idx_nxt));

    byte_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start),
        .i_vld  (w_acc && r_state == DATA),
        .i_byte (bus.rx_data),
        .o_full (w_full),
        .o_word (w_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_csum <= '0;
        else if (w_start)
            r_csum <= '0;
        else if (w_acc && r_state == DATA)
            r_csum <= r_csum ^ bus.rx_data;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (w_start) w_next = LEN0;
            LEN0:            if (w_acc) w_next = LEN1;
            LEN1:            if (w_acc) w_next = w_n_bad ? ERR : DATA;
            DATA:            if (w_full) w_next = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE:           w_next = w_last ? CHK : DATA;
            CHK:             if (w_acc) w_next = (bus.rx_data == r_csum) ? DONE : ERR;
`else
            WRITE:           w_next = w_last ? DONE : DATA;
            CHK:             w_next = IDLE;   // unreachable in this build
`endif
            default:         w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_rx_ready = 1'b0;
        w_we       = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            IDLE:             cpu_hold = 1'b0;
            LEN0, LEN1, DATA,
            CHK:              begin w_rx_ready = 1'b1; busy = 1'b1; end
            WRITE:            begin w_we = 1'b1; busy = 1'b1; end
            DONE:             begin done = 1'b1; cpu_hold = 1'b0; end
            ERR:              err = 1'b1;
            default:          cpu_hold = 1'b0;
        endcase
    end

    // Length, word index and write-port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n     <= '0;
            r_idx   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_start) begin
                r_n   <= '0;
                r_idx <= '0;
            end
            if (w_acc && r_state == LEN0) r_n[7:0]  <= bus.rx_data;
            if (w_acc && r_state == LEN1) r_n[15:8] <= bus.rx_data;
            // Capture on the 4th byte so the write lands the very next cycle;
            // the registers then hold until the following word.
            if (r_state == DATA && w_full) begin
                r_waddr <= r_idx[ADDR_W-1:0];
                r_wdata <= w_word;
            end
            if (r_state == WRITE) r_idx <= w_idx_nxt;
        end
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.we       = w_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err;

    imem_loader_if #(.ADDR_W(8)) bus();

    imem_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int wr_cyc = 0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change at posedge+1, so the negedge sees stable handshakes.
    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) acc_cyc = cyc;
        if (bus.we) begin
            wr_addr.push_back(bus.waddr);
            wr_data.push_back(bus.wdata);
            wr_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.rx_ready) ok = 1'b1;
        end
        if (!ok) chk("rx_ready_timeout", {31'd0, bus.rx_ready}, 32'd1);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b, 0);
`else
        if (b == 8'hxx) tick();   // no checksum byte in this build
`endif
    endtask

    task automatic do_start();
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!done && !err && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done | err}, 32'd1);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #1;
        chk("rst_flags", {26'd0, busy, done, err, cpu_hold, bus.rx_ready, bus.we}, 32'd0);
        chk("rst_waddr", {24'd0, bus.waddr}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Two-word load
        do_start();
        chk("t1_busy_hold", {30'd0, busy, cpu_hold}, 32'd3);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'hE3A00001, 0);
        send_word(32'hE3A01002, 0);
        send_csum(8'h13);
        wait_end("t1_end_timeout");
        chk("t1_flags", {28'd0, done, err, cpu_hold, busy}, 32'b1000);
        chk("t1_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t1_a0", {24'd0, wr_addr[0]}, 32'd0);
            chk("t1_d0", wr_data[0], 32'hE3A00001);
            chk("t1_a1", {24'd0, wr_addr[1]}, 32'd1);
            chk("t1_d1", wr_data[1], 32'hE3A01002);
        end

        // One word with rx_valid low every other cycle
        do_start();
        send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_word(32'h12345678, 1);
        tick();
        chk("t2_wr_latency", wr_cyc - acc_cyc, 32'd1);
        send_csum(8'h08);
        wait_end("t2_end_timeout");
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t2_a0", {24'd0, wr_addr[0]}, 32'd0);
            chk("t2_d0", wr_data[0], 32'h12345678);
        end

        // N = 0
        do_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        repeat (3) tick();
        chk("t3_flags", {28'd0, done, err, cpu_hold, busy}, 32'b0110);
        chk("t3_nwr", wr_addr.size(), 32'd0);

        // N = 257 rejected right after LEN1
        do_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        chk("t4_err", {30'd0, err, cpu_hold}, 32'd3);
        chk("t4_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

        // Reset mid-load
        do_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        reset = 1'b0;
        #1;
        chk("t5_flags", {26'd0, busy, done, err, cpu_hold, bus.rx_ready, bus.we}, 32'd0);
        chk("t5_wdata", bus.wdata, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        do_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'hAABBCCDD, 0);
        send_csum(8'h00);
        wait_end("t5_end_timeout");
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t5_a0", {24'd0, wr_addr[0]}, 32'd0);
            chk("t5_d0", wr_data[0], 32'hAABBCCDD);
        end

        // N = 256, full memory, no wrap
        do_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        chk("t6_accepted", {31'd0, err}, 32'd0);
        for (int i = 0; i < 256; i++) send_word(32'(i), 0);
        send_csum(8'h00);
        wait_end("t6_end_timeout");
        chk("t6_done", {30'd0, done, err}, 32'b10);
        chk("t6_nwr", wr_addr.size(), 32'd256);
        if (wr_addr.size() == 256) begin
            chk("t6_alast", {24'd0, wr_addr[255]}, 32'hFF);
            chk("t6_dlast", wr_data[255], 32'hFF);
            chk("t6_a128", {24'd0, wr_addr[128]}, 32'h80);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'hE3A00001, 0);
        send_byte(8'h42, 0);
        wait_end("c1_end_timeout");
        chk("c1_done", {30'd0, done, err}, 32'b10);

        do_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'hE3A00001, 0);
        send_byte(8'h43, 0);
        wait_end("c2_end_timeout");
        chk("c2_err", {30'd0, done, err}, 32'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
